// File: rtl/axi4_pkg.sv
// Shared definitions for the axi4_slave block: response codes, channel state
// enums, the 4 KB page size and the burst legality check.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned BOUNDARY_4KB = 4096;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // A burst is illegal if its beat size is wider than the bus, if it spills
  // into the next 4 KB page, or if its last byte falls outside the RAM.
  function automatic logic burst_error(input logic [31:0]  start,
                                       input logic [7:0]   len,
                                       input logic [2:0]   size,
                                       input int unsigned  max_size,
                                       input int unsigned  mem_bytes);
    logic [31:0] last;
    logic [31:0] page_mask;
    page_mask = ~(32'(BOUNDARY_4KB) - 32'd1);
    last      = start + ((32'(len) + 32'd1) << size) - 32'd1;
    return (32'(size) > max_size) ||
           ((start & page_mask) != (last & page_mask)) ||
           (last >= mem_bytes);
  endfunction

endpackage

// File: rtl/axi4_memory.sv
// Word RAM behind the AXI4 slave: one synchronous write port and one
// combinational read port, so a read launched on the same edge as a write to
// the same word observes the old contents. Contents are not reset.
module axi4_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024,
  parameter int ADDR_BITS    = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_slave.sv
// AXI4 INCR-burst slave on a single-clock word RAM. Independent write and
// read channel FSMs; all outputs are registered.
// Optional: define AXI4_WLAST_CHECK_EN to flag WLAST/beat-count mismatches
// as SLVERR. Without it WLAST is ignored and the count alone ends a burst.
//
//  state  | meaning
//  W_IDLE | AWREADY high, waiting for a write address
//  W_DATA | WREADY high, accepting beats until count == len
//  W_RESP | BVALID high with BRESP held until BREADY
//  R_IDLE | ARREADY high, waiting for a read address
//  R_DATA | RVALID high, next beat loaded on each R handshake
module axi4_slave
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  input  logic                  WLAST,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  output logic                  RLAST,
  input  logic                  RREADY
);

  localparam int          LANE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int          MEM_AW    = $clog2(MEMORY_DEPTH);
  localparam int unsigned MEM_BYTES = MEMORY_DEPTH * (DATA_WIDTH / 8);

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]            awlen_q, awlen_d, wcnt_q, wcnt_d;
  logic [2:0]            awsize_q, awsize_d;
  logic                  werr_q, werr_d, wlast_err_q, wlast_err_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wbeat_last, wlast_bad, mem_we;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, r_next_addr, r_addr_sel;
  logic [7:0]            arlen_q, arlen_d, rcnt_q, rcnt_d;
  logic [2:0]            arsize_q, arsize_d;
  logic                  rerr_q, rerr_d, r_err_new;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, mem_rdata;
  logic [1:0]            rresp_q, rresp_d;

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  // In idle the RAM is addressed by ARADDR so the first beat is ready at the
  // AR handshake; in data it already points at the following beat.
  assign r_next_addr = araddr_q + (ADDR_WIDTH'(1) << arsize_q);
  assign r_addr_sel  = (r_state_q == R_IDLE) ? ARADDR : r_next_addr;

  axi4_memory #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .ADDR_BITS   (MEM_AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(MEM_AW'(awaddr_q >> LANE_BITS)),
    .wdata(WDATA),
    .raddr(MEM_AW'(r_addr_sel >> LANE_BITS)),
    .rdata(mem_rdata)
  );

`ifndef AXI4_WLAST_CHECK_EN
  logic unused_wlast;
  assign unused_wlast = WLAST;
`endif

  // Write channel next-state: address capture, beat counting, response.
  always_comb begin
    w_state_d   = w_state_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awsize_d    = awsize_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    wlast_err_d = wlast_err_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    mem_we      = 1'b0;
    wbeat_last  = (wcnt_q == awlen_q);
    wlast_bad   = 1'b0;
`ifdef AXI4_WLAST_CHECK_EN
    wlast_bad   = (WLAST != wbeat_last);
`endif
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID && awready_q) begin
          awaddr_d    = AWADDR;
          awlen_d     = AWLEN;
          awsize_d    = AWSIZE;
          werr_d      = burst_error(32'(AWADDR), AWLEN, AWSIZE, LANE_BITS, MEM_BYTES);
          wcnt_d      = 8'd0;
          wlast_err_d = 1'b0;
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          w_state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q) begin
          mem_we      = !werr_q;
          awaddr_d    = awaddr_q + (ADDR_WIDTH'(1) << awsize_q);
          wcnt_d      = wcnt_q + 8'd1;
          wlast_err_d = wlast_err_q | wlast_bad;
          if (wbeat_last) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (werr_q || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel next-state: first beat loaded at AR handshake, then one
  // beat per R handshake with no idle cycles in between.
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_err_new = burst_error(32'(ARADDR), ARLEN, ARSIZE, LANE_BITS, MEM_BYTES);
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          araddr_d  = ARADDR;
          arlen_d   = ARLEN;
          arsize_d  = ARSIZE;
          rerr_d    = r_err_new;
          rcnt_d    = 8'd0;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (ARLEN == 8'd0);
          rdata_d   = r_err_new ? '0 : mem_rdata;
          rresp_d   = r_err_new ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY && rvalid_q) begin
          if (rcnt_q == arlen_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rdata_d   = '0;
            rresp_d   = RESP_OKAY;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            araddr_d = r_next_addr;
            rcnt_d   = rcnt_q + 8'd1;
            rlast_d  = ((rcnt_q + 8'd1) == arlen_q);
            rdata_d  = rerr_q ? '0 : mem_rdata;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q   <= W_IDLE;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      wcnt_q      <= '0;
      werr_q      <= 1'b0;
      wlast_err_q <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      r_state_q   <= R_IDLE;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      rcnt_q      <= '0;
      rerr_q      <= 1'b0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
    end else begin
      w_state_q   <= w_state_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awsize_q    <= awsize_d;
      wcnt_q      <= wcnt_d;
      werr_q      <= werr_d;
      wlast_err_q <= wlast_err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      r_state_q   <= r_state_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      rcnt_q      <= rcnt_d;
      rerr_q      <= rerr_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_slave.sv
// Directed bench for axi4_slave: reset values, single and burst transfers,
// read stalls, out-of-range and 4 KB-crossing errors, concurrent channels.
`timescale 1ns/1ps
module tb_axi4_slave;

  logic        clk = 1'b0;
  logic        ARESETn;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WLAST;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RLAST;
  logic        RREADY;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi4_slave dut (
    .clk(clk), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic write_burst(input logic [15:0] addr, input logic [7:0] len,
                             input logic [31:0] base, input string tag,
                             output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (!AWREADY) begin check({tag, "_awready"}, AWREADY, 1); AWVALID = 1'b0; return; end
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = base + 32'(i); WLAST = (i == int'(len)); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 50) begin @(posedge clk); #1; n++; end
      if (!WREADY) begin check({tag, "_wready"}, WREADY, 1); WVALID = 1'b0; return; end
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (!BVALID) begin check({tag, "_bvalid"}, BVALID, 1); BREADY = 1'b0; return; end
    resp = BRESP;
    @(posedge clk); #1;
    BREADY = 1'b0;
    check({tag, "_bvalid_drop"}, BVALID, 0);
  endtask

  task automatic read_burst(input logic [15:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input logic err,
                            input logic stall, input string tag);
    int n;
    logic [31:0] ed;
    ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin @(posedge clk); #1; n++; end
    if (!ARREADY) begin check({tag, "_arready"}, ARREADY, 1); ARVALID = 1'b0; return; end
    @(posedge clk); #1;
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ed = err ? 32'h0 : base + 32'(i);
      check($sformatf("%s_rvalid%0d", tag, i), RVALID, 1);
      if (!RVALID) begin RREADY = 1'b0; return; end
      if (stall) begin
        RREADY = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s_hold%0d", tag, i), {RVALID, RDATA}, {1'b1, ed});
      end
      RREADY = 1'b1;
      check($sformatf("%s_data%0d", tag, i), RDATA, ed);
      check($sformatf("%s_resp%0d", tag, i), RRESP, err ? 2'b10 : 2'b00);
      check($sformatf("%s_last%0d", tag, i), RLAST, (i == int'(len)));
      @(posedge clk); #1;
    end
    RREADY = 1'b0;
    check({tag, "_end"}, {RVALID, RLAST}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp, cc_resp;
    ARESETn = 1'b0;
    AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
    WDATA = '0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", AWREADY, 0);
    check("rst_wready",  WREADY,  0);
    check("rst_bvalid",  BVALID,  0);
    check("rst_bresp",   BRESP,   0);
    check("rst_arready", ARREADY, 0);
    check("rst_rvalid",  RVALID,  0);
    check("rst_rlast",   RLAST,   0);
    check("rst_rdata",   RDATA,   0);
    check("rst_rresp",   RRESP,   0);
    ARESETn = 1'b1;
    @(posedge clk); #1;
    check("rel_awready", AWREADY, 1);
    check("rel_arready", ARREADY, 1);

    write_burst(16'h0010, 8'd0, 32'hDEADBEEF, "wr1", resp);
    check("wr1_bresp", resp, 2'b00);
    read_burst(16'h0010, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, "rd1");

    write_burst(16'h0100, 8'd3, 32'd1, "wr4", resp);
    check("wr4_bresp", resp, 2'b00);
    read_burst(16'h0100, 8'd3, 32'd1, 1'b0, 1'b0, "rd4");
    read_burst(16'h0100, 8'd3, 32'd1, 1'b0, 1'b1, "rd4s");

    write_burst(16'h0000, 8'd0, 32'hCAFE0000, "wr0", resp);
    check("wr0_bresp", resp, 2'b00);
    write_burst(16'h1000, 8'd0, 32'h12345678, "wroor", resp);
    check("wroor_bresp", resp, 2'b10);
    read_burst(16'h0000, 8'd0, 32'hCAFE0000, 1'b0, 1'b0, "rd0");
    read_burst(16'h1000, 8'd0, 32'h0, 1'b1, 1'b0, "rdoor");

    read_burst(16'h0FF8, 8'd3, 32'h0, 1'b1, 1'b0, "rd4k");

    fork
      write_burst(16'h0200, 8'd3, 32'h100, "ccwr", cc_resp);
      read_burst(16'h0100, 8'd3, 32'd1, 1'b0, 1'b0, "ccrd");
    join
    check("ccwr_bresp", cc_resp, 2'b00);
    read_burst(16'h0200, 8'd3, 32'h100, 1'b0, 1'b0, "ccchk");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_slave.md
Name: axi4_slave

Overview:
- AXI4 memory-mapped slave built on a single-clock word-addressed RAM.
- Supports INCR bursts on independent write (AW/W/B) and read (AR/R) channels.
- No IDs, no WSTRB, no locks/cache/prot signals.
- Sits under the system-level AXI4 interface bundle as the target device; the bench drives the master side.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (byte multiple).
- ADDR_WIDTH, 16, byte address width.
- MEMORY_DEPTH, 1024, number of DATA_WIDTH words in the RAM.

Ports:
- clk  in  1  system clock, rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  write burst start byte address.
- AWLEN  in  8  beats minus one.
- AWSIZE  in  3  log2 bytes per beat.
- AWVALID  in  1; AWREADY  out  1.
- WDATA  in  DATA_WIDTH; WVALID  in  1; WLAST  in  1; WREADY  out  1.
- BRESP  out  2; BVALID  out  1; BREADY  in  1.
- ARADDR  in  ADDR_WIDTH; ARLEN  in  8; ARSIZE  in  3; ARVALID  in  1; ARREADY  out  1.
- RDATA  out  DATA_WIDTH; RRESP  out  2; RVALID  out  1; RLAST  out  1; RREADY  in  1.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; both FSMs enter IDLE. RAM contents are not reset.
- AWREADY and ARREADY rise on the first clk edge after ARESETn deasserts.
- Handshake occurs on a rising edge with VALID and READY both high. Slave outputs never depend combinationally on master inputs.

Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
- W_IDLE: AWREADY=1. On AW handshake, latch addr/len/size, compute the error flag, drop AWREADY, raise WREADY.
- W_DATA: WREADY=1. Each W handshake writes mem[addr>>log2(DATA_WIDTH/8)] unless the error flag is set, then increments addr by 1<<size.
- The burst ends on beat count == len; WLAST is ignored by default. On the last beat, drop WREADY and raise BVALID.
- W_RESP: BVALID=1 and BRESP held stable until B handshake, then return to W_IDLE with AWREADY=1.
- BRESP = OKAY (2'b00), or SLVERR (2'b10) when the error flag is set.

Read FSM (R_IDLE -> R_DATA -> R_IDLE):
- R_IDLE: ARREADY=1. On AR handshake, latch fields, drop ARREADY, load RDATA with the first word, and assert RVALID next cycle. Latency is 1 clk from AR handshake to first RVALID.
- R_DATA: RDATA/RRESP/RLAST hold until R handshake, then the next beat is loaded immediately, with no bubbles.
- RLAST=1 on beat len. After the last handshake: RVALID=0, RLAST=0, ARREADY=1.

Error flag, set at address handshake if any of:
- the size exceeds log2(DATA_WIDTH/8);
- start + ((len+1)<<size) - 1 crosses a 4 KB boundary;
- the last byte is at or beyond MEMORY_DEPTH*DATA_WIDTH/8.

Effect of the error flag:
- Writes are discarded and the response is SLVERR.
- Reads return RDATA=0 with RRESP=SLVERR on every beat; beat count and RLAST are unchanged.

Concurrency and reset:
- Read and write channels operate concurrently.
- Same-cycle write and read to the same word: the read returns the old data.
- Reset mid-burst aborts the burst, discards remaining beats, and no B or R response is issued.

Optional Feature:
- AXI4_WLAST_CHECK_EN defined: WLAST must equal (beat count == len). Any mismatch makes BRESP=SLVERR; the burst still terminates on count, and the beat data is still written if in range.
- AXI4_WLAST_CHECK_EN undefined: WLAST is ignored entirely.

Decomposition:
- Package axi4_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - write and read state enums;
  - the 4 KB boundary constant.
- Sub-module axi4_memory: word RAM of MEMORY_DEPTH x DATA_WIDTH with one synchronous write port and one read port, instantiated once.

Test Plan:
- Reset: hold ARESETn=0 for 3 clocks -> all outputs 0. One clock after release -> AWREADY=1, ARREADY=1.
- Single write then read: AWADDR=0x0010, AWLEN=0, AWSIZE=2, WDATA=0xDEADBEEF -> BRESP=00. Then ARADDR=0x0010 -> RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
- INCR burst: write AWADDR=0x0100, AWLEN=3, data 1..4 -> BRESP=00. Read ARLEN=3 -> 1,2,3,4 with RLAST only on beat 4. RREADY toggling -> data held stable while stalled.
- Out of range: AWADDR=0x1000 (beyond 4 KB RAM) -> BRESP=10 and memory unchanged. Reading the same address -> RDATA=0, RRESP=10.
- 4 KB crossing: ARADDR=0x0FF8, ARLEN=3, ARSIZE=2 -> all 4 beats RRESP=10.
- Concurrency: a 4-beat write and a 4-beat read to disjoint addresses started the same cycle -> both complete with OKAY and correct data.
